// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-side signal bundle for alu_op_sequencer.
// The sequencer takes the slave view; the requester/ALU environment takes the master view.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [WIDTH-1:0] rsp_result_hi;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    input  alu_out, alu_zero, alu_overflow, alu_cout,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_result, rsp_result_hi, rsp_zero, rsp_overflow, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    output alu_out, alu_zero, alu_overflow, alu_cout,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_result, rsp_result_hi, rsp_zero, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Clocked front-end for a combinational 32-bit ALU: single-cycle ADD/SUB/XOR/SLT plus a
// 32-iteration shift-add MUL. Define ALU_SEQ_MULHI_EN to expose the MUL high word.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b100;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             err_q;

  logic             accept;
  logic             mul_last;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] alu_a_c;
  logic [WIDTH-1:0] alu_b_c;
  logic [2:0]       alu_ctrl_c;

  assign accept   = (state == ST_IDLE) && bus.req_valid;
  assign mul_last = (cnt_q == {CNT_W{1'b1}});

  // One shift-add step: the ALU sum (with carry) becomes the new high word and its
  // LSB shifts into the top of the low word as the multiplier bit is consumed.
  assign hi_nxt = {bus.alu_cout, bus.alu_out[WIDTH-1:1]};
  assign lo_nxt = {bus.alu_out[0], lo_q[WIDTH-1:1]};

  // NOTE: every output of a combinational block is given a default first so that no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_a_c    = '0;
    alu_b_c    = '0;
    alu_ctrl_c = 3'b000;
    case (state)
      ST_EXEC: begin
        alu_a_c    = a_q;
        alu_b_c    = b_q;
        alu_ctrl_c = op_q;
      end
      ST_MUL: begin
        alu_a_c    = hi_q;
        alu_b_c    = lo_q[0] ? a_q : '0;
        alu_ctrl_c = OP_ADD;
      end
      default: ;
    endcase
  end

  assign bus.alu_a        = alu_a_c;
  assign bus.alu_b        = alu_b_c;
  assign bus.alu_ctrl     = alu_ctrl_c;
  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.rsp_valid    = (state == ST_RESP);
  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = overflow_q;
  assign bus.rsp_err      = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
            if (bus.req_op[2] == 1'b0) begin
              state <= ST_EXEC;
            end else if (bus.req_op == OP_MUL) begin
              hi_q  <= '0;
              lo_q  <= bus.req_b;
              cnt_q <= '0;
              state <= ST_MUL;
            end else begin
              result_q   <= '0;
              zero_q     <= 1'b0;
              overflow_q <= 1'b0;
              err_q      <= 1'b1;
              state      <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          result_q   <= bus.alu_out;
          zero_q     <= bus.alu_zero;
          overflow_q <= bus.alu_overflow;
          err_q      <= 1'b0;
          state      <= ST_RESP;
        end
        ST_MUL: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            result_q   <= lo_nxt;
            zero_q     <= (lo_nxt == '0);
            overflow_q <= (hi_nxt != '0);
            err_q      <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_MULHI_EN
  logic [WIDTH-1:0] result_hi_q;

  // Cleared on every accept so non-MUL responses report a zero high word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_hi_q <= '0;
    end else if (accept) begin
      result_hi_q <= '0;
    end else if ((state == ST_MUL) && mul_last) begin
      result_hi_q <= hi_nxt;
    end
  end

  assign bus.rsp_result_hi = result_hi_q;
`else
  assign bus.rsp_result_hi = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, directed vector table,
// random ops, backpressure and mid-MUL reset sequences, scoreboard of expected payloads.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum          = '0;
    bus.alu_out      = '0;
    bus.alu_overflow = 1'b0;
    bus.alu_cout     = 1'b0;
    case (bus.alu_ctrl)
      3'b000: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_out      = alu_sum[31:0];
        bus.alu_cout     = alu_sum[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      3'b001: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_out      = alu_sum[31:0];
        bus.alu_cout     = alu_sum[32];
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      3'b010: bus.alu_out = bus.alu_a ^ bus.alu_b;
      3'b011: bus.alu_out = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      default: ;
    endcase
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        err;
  } payload_t;

  typedef struct {
    payload_t p;
    int       lat;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    payload_t    p;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic bad_ctrl = 1'b0;

  always @(negedge clk) if (bus.alu_ctrl == 3'b100) bad_ctrl = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hi_view(input logic [31:0] hi);
`ifdef ALU_SEQ_MULHI_EN
    return hi;
`else
    return (hi & 32'd0);
`endif
  endfunction

  // Independent expectation for random ops
  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] prod;
    logic [31:0] r;
    e.p = '0;
    e.lat = 2;
    case (op)
      3'd0: begin r = a + b; e.p.ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; e.p.ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: begin
        prod = {32'd0, a} * {32'd0, b};
        r = prod[31:0];
        e.p.hi = prod[63:32];
        e.p.ovf = (prod[63:32] != 32'd0);
        e.lat = 33;
      end
      default: begin r = 32'd0; e.p.err = 1'b1; e.lat = 1; end
    endcase
    e.p.result = r;
    e.p.zero = (op <= 3'd4) && (r == 32'd0);
    return e;
  endfunction

  function automatic payload_t snap_payload();
    payload_t s;
    s.result = bus.rsp_result;
    s.hi     = bus.rsp_result_hi;
    s.zero   = bus.rsp_zero;
    s.ovf    = bus.rsp_overflow;
    s.err    = bus.rsp_err;
    return s;
  endfunction

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input exp_t e);
    exp_t     got_e;
    payload_t snap;
    payload_t fin;
    int       n;
    int       edges;
    logic     rdy_leak;
    logic     stable;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    edges = 1;
    rdy_leak = 1'b0;
    while (!bus.rsp_valid && edges < 60) begin
      if (bus.req_ready) rdy_leak = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    check("latency", 64'(edges), 64'(e.lat));
    check("busy_not_ready", {63'd0, rdy_leak}, 64'd0);
    check("alu_idle_in_resp", {bus.alu_ctrl, bus.alu_a[30:0], bus.alu_b[29:0]}, 64'd0);
    snap = snap_payload();
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b000;
      bus.req_a     = 32'h1;
      bus.req_b     = 32'h1;
      if (snap_payload() != snap || !bus.rsp_valid || bus.req_ready) stable = 1'b0;
    end
    if (hold > 0) check("payload_stable", {63'd0, stable}, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    fin = snap_payload();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    got_e = sb_q.pop_front();
    check("result", {32'd0, fin.result}, {32'd0, got_e.p.result});
    check("result_hi", {32'd0, fin.hi}, {32'd0, hi_view(got_e.p.hi)});
    check("flags_zero_ovf_err", {61'd0, fin.zero, fin.ovf, fin.err},
          {61'd0, got_e.p.zero, got_e.p.ovf, got_e.p.err});
    check("after_handshake", {62'd0, bus.rsp_valid, bus.req_ready}, 64'd1);
  endtask

  vec_t vecs[14];

  initial begin
    exp_t e;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    // op, a, b, hold, {result, hi, zero, ovf, err}, latency
    vecs[0]  = '{3'd0, 32'd5,         32'd7,         0, '{32'd12,        32'd0,         1'b0, 1'b0, 1'b0}, 2};
    vecs[1]  = '{3'd1, 32'd3,         32'd3,         0, '{32'd0,         32'd0,         1'b1, 1'b0, 1'b0}, 2};
    vecs[2]  = '{3'd0, 32'h7FFFFFFF,  32'd1,         0, '{32'h80000000,  32'd0,         1'b0, 1'b1, 1'b0}, 2};
    vecs[3]  = '{3'd2, 32'hF0F0F0F0,  32'h0FF00FF0,  5, '{32'hFF00FF00,  32'd0,         1'b0, 1'b0, 1'b0}, 2};
    vecs[4]  = '{3'd3, 32'hFFFFFFFF,  32'd1,         0, '{32'd1,         32'd0,         1'b0, 1'b0, 1'b0}, 2};
    vecs[5]  = '{3'd3, 32'd5,         32'd3,         0, '{32'd0,         32'd0,         1'b1, 1'b0, 1'b0}, 2};
    vecs[6]  = '{3'd4, 32'd12345,     32'd678,       0, '{32'd8369910,   32'd0,         1'b0, 1'b0, 1'b0}, 33};
    vecs[7]  = '{3'd4, 32'h00010000,  32'h00010000,  0, '{32'd0,         32'd1,         1'b1, 1'b1, 1'b0}, 33};
    vecs[8]  = '{3'd4, 32'hFFFFFFFF,  32'hFFFFFFFF,  2, '{32'd1,         32'hFFFFFFFE,  1'b0, 1'b1, 1'b0}, 33};
    vecs[9]  = '{3'd7, 32'd9,         32'd9,         0, '{32'd0,         32'd0,         1'b0, 1'b0, 1'b1}, 1};
    vecs[10] = '{3'd5, 32'd1,         32'd2,         0, '{32'd0,         32'd0,         1'b0, 1'b0, 1'b1}, 1};
    vecs[11] = '{3'd1, 32'd0,         32'd1,         0, '{32'hFFFFFFFF,  32'd0,         1'b0, 1'b0, 1'b0}, 2};
    vecs[12] = '{3'd1, 32'h80000000,  32'd1,         0, '{32'h7FFFFFFF,  32'd0,         1'b0, 1'b1, 1'b0}, 2};
    vecs[13] = '{3'd0, 32'hFFFFFFFF,  32'd1,         0, '{32'd0,         32'd0,         1'b1, 1'b0, 1'b0}, 2};

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_ready_valid", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
    check("reset_payload", {bus.rsp_result, 29'd0, bus.rsp_zero, bus.rsp_overflow, bus.rsp_err}, 64'd0);
    check("reset_alu", {bus.alu_ctrl, bus.alu_a[30:0], bus.alu_b[29:0]}, 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      e.p   = vecs[i].p;
      e.lat = vecs[i].lat;
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold, e);
    end

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? ra : $urandom;
      send(rop, ra, rb, i % 2, ref_model(rop, ra, rb));
    end

    // Reset asserted during MUL iteration 10
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd4;
    bus.req_a     = 32'd12345;
    bus.req_b     = 32'd678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midmul_reset_ready_valid", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
    check("midmul_reset_alu", {61'd0, bus.alu_ctrl}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (bus.rsp_valid || !bus.req_ready) seen = 1'b1;
      end
      check("midmul_no_response", {63'd0, seen}, 64'd0);
    end

    check("mul_ctrl_never_driven", {63'd0, bad_ctrl}, 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
